// File: rtl/baz_tx.sv
// rtl/baz_tx.sv - serial "baz" pattern transmitter, MSB first, with done pulse
// Optional frame repetition with idle gaps is enabled by BAZ_TX_REPEAT_EN.
module baz_tx #(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter int               GAP     = 1,
   parameter int               CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [CNT_W-1:0] rep,
   input  logic             abort,
   output logic             out,
   output logic             frame,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   state_t           r_state, w_nxt_state;
   logic [IDX_W-1:0] r_bit_idx, w_nxt_bit_idx;

`ifdef BAZ_TX_REPEAT_EN
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   logic [CNT_W-1:0] r_rep_cnt, w_nxt_rep_cnt;
   logic [GAP_W-1:0] r_gap_cnt, w_nxt_gap_cnt;
`else
   logic w_unused_rep;
   assign w_unused_rep = ^rep;
`endif

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_bit_idx = r_bit_idx;
`ifdef BAZ_TX_REPEAT_EN
      w_nxt_rep_cnt = r_rep_cnt;
      w_nxt_gap_cnt = r_gap_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_nxt_state   = S_SEND;
               w_nxt_bit_idx = LAST_IDX;
`ifdef BAZ_TX_REPEAT_EN
               w_nxt_rep_cnt = rep;
`endif
            end
         end
         S_SEND: begin
            if (abort) begin
               w_nxt_state = S_IDLE;
`ifdef BAZ_TX_REPEAT_EN
               w_nxt_rep_cnt = '0;
`endif
            end else if (r_bit_idx != '0) begin
               w_nxt_bit_idx = r_bit_idx - IDX_W'(1);
`ifdef BAZ_TX_REPEAT_EN
            end else if (r_rep_cnt != '0) begin
               // Count-down never passes zero, so rep at maximum cannot wrap.
               w_nxt_rep_cnt = r_rep_cnt - CNT_W'(1);
               w_nxt_bit_idx = LAST_IDX;
               if (GAP == 0) begin
                  w_nxt_state = S_SEND;
               end else begin
                  w_nxt_state   = S_GAP;
                  w_nxt_gap_cnt = '0;
               end
`endif
            end else begin
               w_nxt_state = S_DONE;
            end
         end
`ifdef BAZ_TX_REPEAT_EN
         S_GAP: begin
            if (abort) begin
               w_nxt_state   = S_IDLE;
               w_nxt_rep_cnt = '0;
            end else if (r_gap_cnt == GAP_W'(GAP - 1)) begin
               w_nxt_state = S_SEND;
            end else begin
               w_nxt_gap_cnt = r_gap_cnt + GAP_W'(1);
            end
         end
`endif
         S_DONE:  w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_bit_idx <= '0;
`ifdef BAZ_TX_REPEAT_EN
         r_rep_cnt <= '0;
         r_gap_cnt <= '0;
`endif
      end else begin
         r_state   <= w_nxt_state;
         r_bit_idx <= w_nxt_bit_idx;
`ifdef BAZ_TX_REPEAT_EN
         r_rep_cnt <= w_nxt_rep_cnt;
         r_gap_cnt <= w_nxt_gap_cnt;
`endif
      end
   end

   assign out   = (r_state == S_SEND) && PATTERN[r_bit_idx];
   assign frame = (r_state == S_SEND);
   assign busy  = (r_state == S_SEND) || (r_state == S_GAP);
   assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_baz_tx.sv
// tb/tb_baz_tx.sv - directed self-checking bench for baz_tx (both BAZ_TX_REPEAT_EN builds)
module tb_baz_tx;

   logic       clk = 1'b0;
   logic       rstn;
   logic       abort;
   logic       start0, start1;
   logic [3:0] rep0, rep1;
   logic       out0, frame0, busy0, done0;
   logic       out1, frame1, busy1, done1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] o, f, b, d;

   always #5 clk = ~clk;

   baz_tx u_dut0 (
      .clk(clk), .rstn(rstn), .start(start0), .rep(rep0), .abort(abort),
      .out(out0), .frame(frame0), .busy(busy0), .done(done0)
   );

   baz_tx #(.PAT_W(1), .PATTERN(1'b1), .GAP(0), .CNT_W(4)) u_dut1 (
      .clk(clk), .rstn(rstn), .start(start1), .rep(rep1), .abort(abort),
      .out(out1), .frame(frame1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Start is held across one rising edge (E0); rep is then scrambled to prove it was latched.
   task automatic kick(input int sel, input logic [3:0] r);
      @(negedge clk);
      if (sel == 0) begin start0 = 1'b1; rep0 = r; end
      else          begin start1 = 1'b1; rep1 = r; end
      @(posedge clk);
      #1;
      start0 = 1'b0; start1 = 1'b0;
      rep0 = 4'd0;   rep1 = 4'd0;
   endtask

   // Bit i of each vector is the output in cycle i+1 after the start edge.
   task automatic capture(input int sel, input int n, input int abort_cyc, input int start_cyc,
                          output logic [31:0] co, output logic [31:0] cf,
                          output logic [31:0] cb, output logic [31:0] cd);
      co = '0; cf = '0; cb = '0; cd = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         co[i] = (sel == 0) ? out0   : out1;
         cf[i] = (sel == 0) ? frame0 : frame1;
         cb[i] = (sel == 0) ? busy0  : busy1;
         cd[i] = (sel == 0) ? done0  : done1;
         abort = (i + 1 == abort_cyc);
         if (sel == 0) start0 = (i + 1 == start_cyc);
         else          start1 = (i + 1 == start_cyc);
      end
      @(negedge clk);
      abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; abort = 1'b0;
      start0 = 1'b0; start1 = 1'b0; rep0 = 4'd0; rep1 = 4'd0;
      #2;
      check("reset_outs", {28'd0, out0, frame0, busy0, done0, out1, frame1, busy1, done1} >> 4, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      capture(0, 5, 0, 0, o, f, b, d);
      check("idle_out", o, 32'd0);
      check("idle_frame", f, 32'd0);
      check("idle_busy", b, 32'd0);
      check("idle_done", d, 32'd0);

      kick(0, 4'd0);
      capture(0, 6, 0, 0, o, f, b, d);
      check("single_out", o, 32'h05);
      check("single_frame", f, 32'h07);
      check("single_busy", b, 32'h07);
      check("single_done", d, 32'h08);

      kick(0, 4'd2);
      capture(0, 13, 0, 0, o, f, b, d);
`ifdef BAZ_TX_REPEAT_EN
      check("rep2_out", o, 32'h555);
      check("rep2_frame", f, 32'h777);
      check("rep2_busy", b, 32'h7FF);
      check("rep2_done", d, 32'h800);
`else
      check("rep2_out", o, 32'h005);
      check("rep2_frame", f, 32'h007);
      check("rep2_busy", b, 32'h007);
      check("rep2_done", d, 32'h008);
`endif

      kick(0, 4'd2);
      capture(0, 6, 2, 0, o, f, b, d);
      check("abort_out", o, 32'h01);
      check("abort_frame", f, 32'h03);
      check("abort_busy", b, 32'h03);
      check("abort_done", d, 32'h00);

      kick(0, 4'd0);
      capture(0, 8, 0, 2, o, f, b, d);
      check("ign_start_out", o, 32'h05);
      check("ign_start_busy", b, 32'h07);
      check("ign_start_done", d, 32'h08);

      // Start and abort together in IDLE must not launch a frame.
      @(negedge clk);
      start0 = 1'b1; abort = 1'b1;
      capture(0, 4, 0, 0, o, f, b, d);
      check("start_abort_busy", b, 32'h0);

      kick(0, 4'd0);
      capture(0, 1, 0, 0, o, f, b, d);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("async_rst_outs", {28'd0, out0, frame0, busy0, done0}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      capture(0, 5, 0, 0, o, f, b, d);
      check("post_rst_busy", b, 32'd0);
      check("post_rst_done", d, 32'd0);
      kick(0, 4'd0);
      capture(0, 6, 0, 0, o, f, b, d);
      check("post_rst_out", o, 32'h05);
      check("post_rst_fdone", d, 32'h08);

      kick(1, 4'd15);
      capture(1, 19, 0, 0, o, f, b, d);
`ifdef BAZ_TX_REPEAT_EN
      check("max_rep_out", o, 32'h0FFFF);
      check("max_rep_busy", b, 32'h0FFFF);
      check("max_rep_done", d, 32'h10000);
`else
      check("max_rep_out", o, 32'h1);
      check("max_rep_busy", b, 32'h1);
      check("max_rep_done", d, 32'h2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
